// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the CPU trace monitor: run-state values and the default halt opcode.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_t;

    localparam logic [5:0] DEF_HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/cpu_trace_monitor_ring_buf.sv
// Trace ring buffer: DEPTH entries of {pc, instruction}, oldest-first combinational read.
module trace_ring_buf #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end
    end

    // Storage carries no reset; entries beyond count are masked on read.
    always_ff @(posedge clk) begin
        if (wr_en && !clr)
            mem[wr_ptr] <= wr_data;
    end

    // A full buffer has count[PTR_W-1:0] == 0, so the oldest entry is wr_ptr itself.
    assign rd_ptr  = wr_ptr - count[PTR_W-1:0] + rd_idx;
    assign rd_data = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run-control and trace monitor for the multicycle CPU: counts cycles, retirements and
// write-backs, stops on HALT or cycle timeout, and keeps the last DEPTH retired instructions.
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  ST_IDLE    | waiting for start after reset
//  ST_RUN     | counting and tracing every cycle
//  ST_HALTED  | HALT opcode retired; results frozen
//  ST_TIMEOUT | MAX_CYCLES run cycles elapsed; results frozen
module cpu_trace_monitor
    import cpu_trace_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         DEPTH       = 16,
    parameter int         CNT_W       = 32,
    parameter int         MAX_CYCLES  = 75,
    parameter logic [5:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       pc_wre,
    input  logic [DATA_W-1:0]          pc,
    input  logic [DATA_W-1:0]          instruction,
    input  logic                       reg_wre,
    input  logic [4:0]                 wb_reg,
    input  logic [$clog2(DEPTH)-1:0]   trace_rd_idx,
    output logic [DATA_W-1:0]          trace_rd_pc,
    output logic [DATA_W-1:0]          trace_rd_instr,
    output logic [$clog2(DEPTH):0]     trace_count,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           instr_count,
    output logic [CNT_W-1:0]           wb_count,
    output logic [1:0]                 state,
    output logic                       done
);

    localparam int TMR_W = $clog2(MAX_CYCLES + 1);

    run_state_t          state_q, state_d;
    logic [TMR_W-1:0]    tmr;
    logic                clr;
    logic                in_run;
    logic                halt_hit;
    logic                wb_hit;
    logic [2*DATA_W-1:0] rd_data;

    assign halt_hit = pc_wre && (instruction[31:26] == HALT_OPCODE);
    assign wb_hit   = reg_wre && (wb_reg != 5'd0);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        in_run  = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_run = 1'b1;
                if (halt_hit)
                    state_d = ST_HALTED;
                else if (tmr == '0)
                    state_d = ST_TIMEOUT;
            end
            default: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // tmr is a down-counter of remaining RUN cycles; zero marks the timeout edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr         <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            wb_count    <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                tmr         <= TMR_W'(MAX_CYCLES - 1);
                cycle_count <= '0;
                instr_count <= '0;
                wb_count    <= '0;
            end else if (in_run) begin
                cycle_count <= cycle_count + CNT_W'(1);
                if (tmr != '0)
                    tmr <= tmr - TMR_W'(1);
                if (pc_wre)
                    instr_count <= instr_count + CNT_W'(1);
                if (wb_hit)
                    wb_count <= wb_count + CNT_W'(1);
            end
        end
    end

    trace_ring_buf #(
        .DEPTH (DEPTH),
        .WIDTH (2*DATA_W)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (in_run && pc_wre),
        .wr_data ({pc, instruction}),
        .rd_idx  (trace_rd_idx),
        .rd_data (rd_data),
        .count   (trace_count)
    );

    assign trace_rd_pc    = rd_data[2*DATA_W-1:DATA_W];
    assign trace_rd_instr = rd_data[DATA_W-1:0];
    assign state          = state_q;
    assign done           = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: directed scenarios plus random runs
// compared each cycle against a queue-based reference model.
module tb_cpu_trace_monitor;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 32;
    localparam int MAXC   = 75;
    localparam int IW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              pc_wre = 1'b0;
    logic [DATA_W-1:0] pc = '0;
    logic [DATA_W-1:0] instruction = '0;
    logic              reg_wre = 1'b0;
    logic [4:0]        wb_reg = '0;
    logic [IW-1:0]     trace_rd_idx = '0;
    logic [DATA_W-1:0] trace_rd_pc;
    logic [DATA_W-1:0] trace_rd_instr;
    logic [IW:0]       trace_count;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  instr_count;
    logic [CNT_W-1:0]  wb_count;
    logic [1:0]        state;
    logic              done;

    cpu_trace_monitor #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc_wre(pc_wre), .pc(pc),
        .instruction(instruction), .reg_wre(reg_wre), .wb_reg(wb_reg),
        .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc),
        .trace_rd_instr(trace_rd_instr), .trace_count(trace_count),
        .cycle_count(cycle_count), .instr_count(instr_count), .wb_count(wb_count),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: state as spec integer, counters as ints, trace as a queue.
    int          m_state;
    longint      m_cyc, m_ins, m_wb;
    logic [63:0] m_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_cyc = 0; m_ins = 0; m_wb = 0;
        m_q.delete();
    endtask

    // Applies the spec rules to the inputs present at the coming edge.
    task automatic model_step();
        bit halt, tmo;
        if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_cyc = 0; m_ins = 0; m_wb = 0;
                m_q.delete();
            end
        end else begin
            halt = pc_wre && (instruction[31:26] == 6'b111111);
            tmo  = (m_cyc == MAXC - 1);
            m_cyc++;
            if (pc_wre) begin
                m_ins++;
                m_q.push_back({pc, instruction});
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end
            if (reg_wre && wb_reg != 0) m_wb++;
            if (halt) m_state = 2;
            else if (tmo) m_state = 3;
        end
    endtask

    task automatic check_idx(input int idx);
        logic [63:0] e;
        trace_rd_idx = IW'(idx);
        #1;
        e = (idx < m_q.size()) ? m_q[idx] : 64'd0;
        chk("rd_pc", 64'(trace_rd_pc), 64'(e[63:32]));
        chk("rd_instr", 64'(trace_rd_instr), 64'(e[31:0]));
    endtask

    task automatic check_all();
        chk("state", 64'(state), 64'(m_state));
        chk("done", 64'(done), 64'(m_state >= 2));
        chk("cycle_count", 64'(cycle_count), 64'(m_cyc[CNT_W-1:0]));
        chk("instr_count", 64'(instr_count), 64'(m_ins[CNT_W-1:0]));
        chk("wb_count", 64'(wb_count), 64'(m_wb[CNT_W-1:0]));
        chk("trace_count", 64'(trace_count), 64'(m_q.size()));
        check_idx(int'($urandom_range(0, DEPTH - 1)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit st, input bit pw, input logic [31:0] p,
                         input logic [31:0] ins, input bit rw, input logic [4:0] wr);
        start = st; pc_wre = pw; pc = p; instruction = ins; reg_wre = rw; wb_reg = wr;
    endtask

    function automatic logic [31:0] rand_nonhalt();
        logic [31:0] v;
        v = $urandom;
        if (v[31:26] == 6'b111111) v[26] = 1'b0;
        return v;
    endfunction

    task automatic idle_inputs();
        drive(0, 0, '0, '0, 0, '0);
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        #1;
        check_all();

        // 1: three retirements then HALT
        drive(1, 0, '0, '0, 0, '0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'(4*k), rand_nonhalt(), 0, '0); tick();
        end
        drive(0, 1, 32'd12, 32'hFC000000, 0, '0); tick();
        idle_inputs(); tick();
        chk("t1_state", 64'(state), 64'd2);
        chk("t1_instr_count", 64'(instr_count), 64'd4);
        chk("t1_trace_count", 64'(trace_count), 64'd4);
        check_idx(0);
        chk("t1_idx0_pc", 64'(trace_rd_pc), 64'd0);
        check_idx(3);
        chk("t1_idx3_instr", 64'(trace_rd_instr), 64'hFC000000);

        // 2: timeout with no retirements
        drive(1, 0, '0, '0, 0, '0); tick();
        idle_inputs();
        for (int k = 0; k < MAXC - 1; k++) tick();
        chk("t2_still_run", 64'(state), 64'd1);
        tick();
        chk("t2_state", 64'(state), 64'd3);
        chk("t2_cycle_count", 64'(cycle_count), 64'(MAXC));
        chk("t2_instr_count", 64'(instr_count), 64'd0);
        chk("t2_done", 64'(done), 64'd1);

        // 3: ring wrap, plus start ignored while running
        drive(1, 0, '0, '0, 0, '0); tick();
        for (int k = 0; k < 20; k++) begin
            drive(k == 10, 1, 32'(4*k), rand_nonhalt(), 0, '0); tick();
        end
        chk("t3_trace_count", 64'(trace_count), 64'd16);
        chk("t6_ignored_start", 64'(instr_count), 64'd20);
        check_idx(0);
        chk("t3_idx0_pc", 64'(trace_rd_pc), 64'd16);
        check_idx(15);
        chk("t3_idx15_pc", 64'(trace_rd_pc), 64'd76);
        idle_inputs();
        while (m_state == 1) tick();

        // 4: halt coincides with the timeout edge
        drive(1, 0, '0, '0, 0, '0); tick();
        for (int k = 0; k < MAXC - 1; k++) begin
            drive(0, $urandom_range(0, 1), $urandom, rand_nonhalt(), 0, '0); tick();
        end
        drive(0, 1, 32'h100, 32'hFFFF0000, 0, '0); tick();
        chk("t4_state", 64'(state), 64'd2);
        chk("t4_cycle_count", 64'(cycle_count), 64'(MAXC));

        // 6: restart from HALTED clears and starts a fresh trace
        drive(1, 0, '0, '0, 0, '0); tick();
        chk("t6_cleared", 64'(cycle_count), 64'd0);
        chk("t6_trace_cleared", 64'(trace_count), 64'd0);
        drive(0, 1, 32'h200, 32'h12345678, 0, '0); tick();
        check_idx(0);
        chk("t6_idx0_pc", 64'(trace_rd_pc), 64'h200);

        // 5: write-back filter, then async reset mid-run
        drive(0, 0, '0, '0, 1, 5'd0); tick();
        drive(0, 0, '0, '0, 1, 5'd3); tick();
        drive(0, 0, '0, '0, 1, 5'd0); tick();
        drive(0, 0, '0, '0, 1, 5'd7); tick();
        chk("t5_wb_count", 64'(wb_count), 64'd2);
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t5_rst_state", 64'(state), 64'd0);
        chk("t5_rst_cycle", 64'(cycle_count), 64'd0);
        rst = 1'b0;

        // Random runs
        for (int c = 0; c < 2500; c++) begin
            r = $urandom;
            drive(r[3:0] == 4'd0, r[4] | r[5],
                  {$urandom_range(0, 255), 2'b00},
                  (r[12:6] == 7'd0) ? {6'b111111, 26'($urandom)} : rand_nonhalt(),
                  r[13], 5'($urandom_range(0, 31)));
            if (r[31:22] == 10'd0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
